// File: rtl/miner_csr_regbus.sv
// Regbus CSR bank for the hash core: control, nonce seed, header words,
// status, result nonce and a sticky done interrupt. One execution per access.
module miner_csr_regbus #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int NUM_DATA = 8
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  input  logic                       addr_valid,
  input  logic                       reg_write,
  input  logic [ADDR_W-1:0]          reg_addr,
  input  logic [DATA_W-1:0]          reg_wdata,
  output logic                       reg_ready,
  output logic [DATA_W-1:0]          reg_rdata,
  output logic                       start_o,
  output logic [DATA_W-1:0]          nonce_start_o,
  output logic [NUM_DATA*DATA_W-1:0] data_o,
  input  logic                       core_busy_i,
  input  logic                       core_done_i,
  input  logic                       core_found_i,
  input  logic [DATA_W-1:0]          nonce_result_i,
  output logic                       irq_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK, HOLD} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [5:0]        idx_q;
  logic              wr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              irq_en;
  logic              done_q;
  logic              found_q;
  logic [DATA_W-1:0] nonce_start_q;
  logic [DATA_W-1:0] result_q;
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] data_q [NUM_DATA];
  logic              wr_en;
  logic              unused_addr;

  // Only word offset bits [7:2] take part in decoding.
  assign unused_addr = ^{reg_addr[ADDR_W-1:8], reg_addr[1:0]};

  assign wr_en     = (state == ACCESS) && wr_q;
  assign reg_ready = (state == ACK);
  assign nonce_start_o = nonce_start_q;

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: HOLD waits for addr_valid to drop so a level request runs once.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (addr_valid) state_nxt = ACCESS;
      ACCESS:  state_nxt = ACK;
      ACK:     state_nxt = HOLD;
      HOLD:    if (!addr_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the request when it is accepted from IDLE.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else if (state == IDLE && addr_valid) begin
      idx_q   <= reg_addr[7:2];
      wr_q    <= reg_write;
      wdata_q <= reg_wdata;
    end
  end

  // Software-writable registers, updated at the end of ACCESS.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      irq_en        <= 1'b0;
      nonce_start_q <= '0;
      for (int i = 0; i < NUM_DATA; i++) data_q[i] <= '0;
    end else if (wr_en) begin
      if (idx_q == 6'd0) irq_en <= wdata_q[1];
      if (idx_q == 6'd3) nonce_start_q <= wdata_q;
      for (int i = 0; i < NUM_DATA; i++)
        if (idx_q == 6'(8 + i)) data_q[i] <= wdata_q;
    end
  end

  // Core-side status; a done pulse beats a same-cycle W1C clear.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      result_q <= '0;
    end else begin
      if (core_done_i) begin
        done_q  <= 1'b1;
        found_q <= core_found_i;
        if (core_found_i) result_q <= nonce_result_i;
      end else if (wr_en && idx_q == 6'd2 && wdata_q[0]) begin
        done_q <= 1'b0;
      end
    end
  end

  // Start pulse and registered interrupt level.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      start_o <= 1'b0;
      irq_o   <= 1'b0;
    end else begin
      start_o <= wr_en && idx_q == 6'd0 && wdata_q[0] && !core_busy_i;
      irq_o   <= irq_en & done_q;
    end
  end

  // Read mux; unmapped offsets and unused bits return 0.
  always_comb begin
    rdata_d = '0;
    case (idx_q)
      6'd0: rdata_d[1] = irq_en;
      6'd1: begin
        rdata_d[0] = core_busy_i;
        rdata_d[1] = found_q;
      end
      6'd2: rdata_d[0] = done_q;
      6'd3: rdata_d = nonce_start_q;
      6'd4: rdata_d = result_q;
      default: begin
        for (int i = 0; i < NUM_DATA; i++)
          if (idx_q == 6'(8 + i)) rdata_d = data_q[i];
      end
    endcase
  end

  // Read data is registered in ACCESS so it is stable during ACK.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                  reg_rdata <= '0;
    else if (state == ACCESS) reg_rdata <= wr_q ? '0 : rdata_d;
  end

  // Flatten header words for the core.
  for (genvar g = 0; g < NUM_DATA; g++) begin : g_data
    assign data_o[g*DATA_W +: DATA_W] = data_q[g];
  end

endmodule
